// File: rtl/spike_collector.sv
// spike_collector: captures neuron spikes per time step and serialises them into addresses through a FWFT FIFO
module spike_collector #(
    parameter int NUM_NEURONS = 32,
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_step,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   busy,
    output logic                   scan_done,
    output logic [7:0]             step_spike_count,
    output logic                   overrun
);
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] sticky_q, sticky_d, scan_q, scan_d, masked, pick, captured, scan_left;
    logic [IW-1:0]          pos_q, pos_d, idx;
    logic [7:0]             cur_count_q, cur_count_d, cnt_inc, step_count_q, step_count_d;
    logic                   scan_done_q, overrun_q, overrun_d;
    logic [PW:0]            wr_q, rd_q;
    logic [ADDR_W-1:0]      mem [FIFO_DEPTH];
    logic                   empty, full, scanning, push, pop, finish, entry;
    logic [ADDR_W-1:0]      push_addr;
    assign empty            = wr_q == rd_q;
    assign full             = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);
    assign scanning         = state_q == SCAN;
    assign push             = scanning && |scan_q && !full;
    assign pop              = !empty && out_ready;
    assign out_valid        = !empty;
    assign out_addr         = empty ? '0 : mem[rd_q[PW-1:0]];
    assign busy             = scanning;
    assign scan_done        = scan_done_q;
    assign step_spike_count = step_count_q;
    assign overrun          = overrun_q;
    // Pick the lowest pending index at or above the last pushed position, wrapping to the lowest overall
    always_comb begin
        masked = scan_q & ({NUM_NEURONS{1'b1}} << pos_q);
        pick   = |masked ? masked : scan_q;
        idx    = '0;
        for (int k = NUM_NEURONS - 1; k >= 0; k--)
            if (pick[k]) idx = IW'(k);
    end
    // Next-state for capture, scan vector, counters and step completion
    always_comb begin
        entry        = time_step && !scanning;
        captured     = sticky_q | spikes_in;
        scan_left    = push ? scan_q & ~(NUM_NEURONS'(1) << idx) : scan_q;
        scan_d       = time_step ? scan_left | captured : scan_left;
        sticky_d     = time_step ? '0 : captured;
        cnt_inc      = push && cur_count_q != 8'hFF ? cur_count_q + 8'd1 : cur_count_q;
        cur_count_d  = entry ? '0 : cnt_inc;
        pos_d        = entry ? '0 : push ? idx : pos_q;
        finish       = scanning && scan_d == '0;
        state_d      = finish ? IDLE : time_step ? SCAN : state_q;
        step_count_d = finish ? cnt_inc : step_count_q;
        overrun_d    = overrun_q | (time_step && scanning);
        push_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
    end
    // Control state and FIFO pointers, reset discards everything pending
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sticky_q     <= '0;
            scan_q       <= '0;
            pos_q        <= '0;
            cur_count_q  <= '0;
            step_count_q <= '0;
            scan_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            sticky_q     <= sticky_d;
            scan_q       <= scan_d;
            pos_q        <= pos_d;
            cur_count_q  <= cur_count_d;
            step_count_q <= step_count_d;
            scan_done_q  <= finish;
            overrun_q    <= overrun_d;
            wr_q         <= wr_q + (PW+1)'(push);
            rd_q         <= rd_q + (PW+1)'(pop);
        end
    end
    // FIFO storage needs no reset since the pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_q[PW-1:0]] <= push_addr;
    end
endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: randomized and directed checks of spike_collector against a step-level reference model
module tb_spike_collector;
    localparam int BASE = 100;
    logic        clk = 0, rst = 1, time_step = 0, out_ready = 0;
    logic [31:0] spikes_in = '0;
    logic        out_valid, busy, scan_done, overrun;
    logic [9:0]  out_addr;
    logic [7:0]  step_spike_count;
    int          errors = 0, checks = 0, pops = 0, p0;
    bit          manual = 0, rnd_rdy = 0;
    logic [31:0] acc = '0;
    int          exp_addr[$], exp_cnt[$];

    spike_collector #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .time_step(time_step), .spikes_in(spikes_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .busy(busy), .scan_done(scan_done), .step_spike_count(step_spike_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sparse();
        return $urandom & $urandom & $urandom;
    endfunction

    // Apply one cycle of inputs and update the reference model with what the DUT sampled
    task automatic drive(input logic ts, input logic [31:0] spk);
        logic [31:0] v;
        time_step = ts;
        spikes_in = spk;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (rst) begin
            acc = '0;
            exp_addr.delete();
            exp_cnt.delete();
        end else if (ts) begin
            v   = acc | spk;
            acc = '0;
            if (!manual) begin
                for (int i = 0; i < 32; i++) if (v[i]) exp_addr.push_back(BASE + i);
                exp_cnt.push_back($countones(v));
            end
        end else acc |= spk;
        #1;
        time_step = 0;
        spikes_in = '0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while ((busy || out_valid) && n < 400) begin
            drive(0, rnd ? sparse() : '0);
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", n, 0);
    endtask

    // Scoreboard: every handshake and every step completion is checked against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                pops++;
                chk("addr", out_addr, exp_addr.size() ? exp_addr.pop_front() : 32'hFFFF_FFFF);
            end
            if (scan_done) chk("count", step_spike_count, exp_cnt.size() ? exp_cnt.pop_front() : 32'hFFFF_FFFF);
        end
    end

    initial begin
        rst = 1;
        drive(0, '0);
        drive(0, '0);
        rst = 0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_count", step_spike_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", out_addr, 0);
        // empty step
        drive(1, '0);
        @(negedge clk);
        chk("empty_busy", busy, 1);
        @(negedge clk);
        chk("empty_busy_end", busy, 0);
        chk("empty_done", scan_done, 1);
        chk("empty_valid", out_valid, 0);
        @(negedge clk);
        chk("empty_done_pulse", scan_done, 0);
        // three spikes on separate cycles
        out_ready = 1;
        drive(0, 32'h1 << 3);
        drive(0, 32'h1 << 7);
        drive(0, 32'h1 << 31);
        drive(1, '0);
        @(negedge clk);
        chk("lat_valid", out_valid, 0);
        @(negedge clk);
        chk("seq0", out_addr, BASE + 3);
        @(negedge clk);
        chk("seq1", out_addr, BASE + 7);
        @(negedge clk);
        chk("seq2", out_addr, BASE + 31);
        wait_idle(0);
        // all spikes with a blocked consumer
        out_ready = 0;
        p0 = pops;
        drive(1, '1);
        for (int i = 0; i < 20; i++) drive(0, '0);
        @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", out_addr, BASE);
        drive(0, '0);
        @(negedge clk);
        chk("stall_stable", out_addr, BASE);
        out_ready = 1;
        wait_idle(0);
        chk("stall_pops", pops - p0, 32);
        // overrun: second step merges bit 0 while bits 2,4,6 are being scanned
        manual = 1;
        exp_addr.push_back(BASE + 2);
        exp_addr.push_back(BASE + 4);
        exp_addr.push_back(BASE + 6);
        exp_addr.push_back(BASE + 0);
        exp_cnt.push_back(4);
        p0 = pops;
        drive(1, 32'h54);
        drive(1, 32'h1);
        @(negedge clk);
        chk("overrun_flag", overrun, 1);
        wait_idle(0);
        manual = 0;
        chk("overrun_pops", pops - p0, 4);
        chk("overrun_sticky", overrun, 1);
        // reset mid-scan with a partly filled FIFO
        out_ready = 0;
        drive(1, 32'hFFF);
        for (int i = 0; i < 7; i++) drive(0, '0);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_valid", out_valid, 1);
        rst = 1;
        drive(0, 32'h1 << 9);
        rst = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        out_ready = 1;
        p0 = pops;
        drive(0, 32'h1 << 20);
        drive(1, '0);
        @(negedge clk);
        wait_idle(0);
        chk("post_rst_pops", pops - p0, 1);
        // spike in the time_step cycle belongs to the ending step
        p0 = pops;
        drive(1, 32'h1 << 5);
        @(negedge clk);
        wait_idle(0);
        drive(1, '0);
        @(negedge clk);
        wait_idle(0);
        chk("same_cycle_pops", pops - p0, 1);
        // randomized steps with random consumer back-pressure
        rnd_rdy = 1;
        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(0, 4);
            for (int c = 0; c < n; c++) drive(0, sparse());
            drive(1, it % 8 == 7 ? $urandom | $urandom : sparse());
            @(negedge clk);
            wait_idle(1);
        end
        rnd_rdy = 0;
        out_ready = 1;
        @(negedge clk);
        wait_idle(0);
        chk("drain_addr", exp_addr.size(), 0);
        chk("drain_count", exp_cnt.size(), 0);
        chk("no_overrun", overrun, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
